// File: rtl/apb4_master_bridge.sv
// APB4 initiator: one valid/ready command at a time becomes a SETUP/ACCESS transfer, and the result is held on the response port.
// Zero-wait latency is 3 cycles from command to rsp_valid_o. cmd_ready_o is high only in IDLE. Defining APB4_MST_TIMEOUT_EN adds an ACCESS-phase abort.
module apb4_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("apb4_master_bridge: illegal DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
    logic [2:0]            prot;
  } apb_req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  state_e   state_q;
  apb_req_t req_q;
  apb_rsp_t rsp_q;
  logic     psel_q;
  logic     penable_q;
  logic     rsp_valid_q;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 timeout_q;
  assign rsp_timeout_o = timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Ready is a decode of the state register, so it is high while reset holds the FSM in IDLE.
  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;
  assign paddr_o     = req_q.addr;
  assign pprot_o     = req_q.prot;
  assign pwrite_o    = req_q.write;
  assign pwdata_o    = req_q.wdata;
  assign pstrb_o     = req_q.strb;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            req_q.addr  <= cmd_addr_i;
            req_q.write <= cmd_write_i;
            req_q.wdata <= cmd_wdata_i;
            req_q.prot  <= cmd_prot_i;
            req_q.strb  <= cmd_write_i ? cmd_strb_i : '0;
            psel_q      <= 1'b1;
            state_q     <= SETUP;
`ifdef APB4_MST_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A completing slave wins over a watchdog expiring in the same cycle.
          if (pready_i) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_q.err   <= pslverr_i;
            rsp_q.rdata <= (!req_q.write && !pslverr_i) ? prdata_i : '0;
            state_q     <= RESP;
          end
`ifdef APB4_MST_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_q.err   <= 1'b1;
            rsp_q.rdata <= '0;
            timeout_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            state_q     <= IDLE;
`ifdef APB4_MST_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed plus randomized bench for apb4_master_bridge, using a memory-backed APB slave and a command-level reference memory.
module tb_apb4_master_bridge;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic [2:0]  cmd_prot_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i, pslverr_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem   [16];

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i), .cmd_prot_i(cmd_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Starts and ends at a negedge with the bridge idle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                      input logic [2:0] prot, input int waits, input bit err, input int hold, input bit keep);
    logic [31:0] exp_rd;
    chk("idle_cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd;
    cmd_strb_i = strb; cmd_prot_i = prot;
    @(negedge clk_i);
    cmd_valid_i = keep;
    chk("setup_psel", psel_o, 1);
    chk("setup_penable", penable_o, 0);
    chk("setup_cmd_ready", cmd_ready_o, 0);
    chk("setup_paddr", paddr_o, addr);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk_i);
      chk("access_psel", psel_o, 1);
      chk("access_penable", penable_o, 1);
      chk("access_paddr", paddr_o, addr);
      chk("access_pwrite", pwrite_o, wr);
      chk("access_pstrb", pstrb_o, wr ? strb : 4'h0);
      chk("access_pprot", pprot_o, prot);
      if (wr) chk("access_pwdata", pwdata_o, wd);
      chk("access_rsp_valid", rsp_valid_o, 0);
      chk("access_cmd_ready", cmd_ready_o, 0);
      if (i == waits) begin
        pready_i = 1'b1; pslverr_i = err;
        prdata_i = wr ? $urandom : slave_mem[paddr_o[5:2]];
        if (pwrite_o && !err) slave_mem[paddr_o[5:2]] = merge(slave_mem[paddr_o[5:2]], pwdata_o, pstrb_o);
      end else begin
        pready_i = 1'b0; pslverr_i = 1'($urandom_range(0, 1)); prdata_i = $urandom;
      end
    end
    @(negedge clk_i);
    pready_i = 1'b0; pslverr_i = 1'b0;
    exp_rd = (!wr && !err) ? ref_mem[addr[5:2]] : 32'h0;
    if (wr && !err) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wd, strb);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid_o, 1);
      chk("rsp_rdata", rsp_rdata_o, exp_rd);
      chk("rsp_err", rsp_err_o, err);
      chk("rsp_timeout", rsp_timeout_o, 0);
      chk("rsp_psel", psel_o, 0);
      chk("rsp_penable", penable_o, 0);
      chk("rsp_cmd_ready", cmd_ready_o, 0);
      rsp_ready_i = (h == hold);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;
    chk("done_rsp_valid", rsp_valid_o, 0);
    chk("done_rsp_rdata", rsp_rdata_o, 0);
    chk("done_rsp_err", rsp_err_o, 0);
    chk("done_cmd_ready", cmd_ready_o, 1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          w, e;
    int          gap;
    rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_strb_i = '0; cmd_prot_i = '0; rsp_ready_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i] = slave_mem[i];
    end
    slave_mem[2] = 32'h12345678; ref_mem[2] = 32'h12345678;

    @(negedge clk_i); @(negedge clk_i);
    chk("reset_psel", psel_o, 0);
    chk("reset_penable", penable_o, 0);
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_rsp_err", rsp_err_o, 0);
    chk("reset_rsp_rdata", rsp_rdata_o, 0);
    chk("reset_paddr", paddr_o, 0);
    chk("reset_pstrb", pstrb_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_cmd_ready", cmd_ready_o, 1);

    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0, 0, 0, 0);
    xfer(0, 32'h08, 32'h0, 4'hF, 3'h2, 3, 0, 0, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 3'h1, 1, 0, 0, 0);
    xfer(0, 32'h0C, 32'h0, 4'h0, 3'h5, 2, 1, 0, 0);
    xfer(1, 32'h04, 32'hCAFEF00D, 4'h5, 3'h7, 0, 1, 0, 0);
    // Response stalled 5 cycles while the next command is already pending.
    xfer(1, 32'h20, 32'hA5A55A5A, 4'h6, 3'h3, 1, 0, 5, 1);
    xfer(1, 32'h20, 32'hA5A55A5A, 4'h6, 3'h3, 0, 0, 0, 0);
    xfer(0, 32'h20, 32'h0, 4'h0, 3'h0, 0, 0, 0, 0);

    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 4) == 0);
      a = 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      xfer(w, a, d, s, 3'($urandom_range(0, 7)), $urandom_range(0, 3), e, $urandom_range(0, 2), 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk_i);
        chk("gap_psel", psel_o, 0);
        chk("gap_cmd_ready", cmd_ready_o, 1);
      end
    end

`ifdef APB4_MST_TIMEOUT_EN
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h18; cmd_strb_i = 4'h0; cmd_prot_i = 3'h0;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk_i);
      chk("to_access_penable", penable_o, 1);
      pready_i = 1'b0; prdata_i = $urandom;
    end
    @(negedge clk_i);
    chk("to_rsp_valid", rsp_valid_o, 1);
    chk("to_rsp_err", rsp_err_o, 1);
    chk("to_rsp_timeout", rsp_timeout_o, 1);
    chk("to_rsp_rdata", rsp_rdata_o, 0);
    chk("to_psel", psel_o, 0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("to_done_timeout", rsp_timeout_o, 0);
    xfer(0, 32'h18, 32'h0, 4'h0, 3'h0, TO - 1, 0, 0, 0);
`endif

    // Asynchronous reset in the middle of an ACCESS phase.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h30; cmd_strb_i = 4'hF; cmd_prot_i = 3'h4;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_penable", penable_o, 1);
    pready_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    chk("rst_release_cmd_ready", cmd_ready_o, 1);
    @(negedge clk_i);
    chk("rst_release_psel", psel_o, 0);
    xfer(0, 32'h08, 32'h0, 4'h0, 3'h0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
